// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions for the return-address stack.
// Provides default RAS geometry and the priority-decoded operation type.
package cpu_pkg;

    localparam int RAS_WIDTH = 16;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL,
        RAS_RESTORE
    } ras_op_e;

endpackage

// File: rtl/ras_spec_if.sv
// Request/response bundle of the return-address stack.
// master: fetch logic (push/pop/checkpoint requests); slave: the stack.
interface ras_spec_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = RAS_WIDTH,
    parameter int DEPTH = RAS_DEPTH
);

    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             ckpt_save;
    logic             ckpt_restore;
    logic [WIDTH-1:0] new_data;
    logic [WIDTH-1:0] top_of_stack;
    logic             valid;
    logic             full;
    logic [CW-1:0]    count;
    logic             err;

    modport master (
        output push, pop, ckpt_save, ckpt_restore, new_data,
        input  top_of_stack, valid, full, count, err
    );

    modport slave (
        input  push, pop, ckpt_save, ckpt_restore, new_data,
        output top_of_stack, valid, full, count, err
    );

endinterface

// File: rtl/ras_ptr_ctl.sv
// Pointer, count and overflow control for the return-address stack.
// Ports: clk/rst, decoded op, snapshot ptr/count in; ptr/count state,
// next values, write enable/index, err, full and valid out.
module ras_ptr_ctl
    import cpu_pkg::*;
#(
    parameter int DEPTH    = RAS_DEPTH,
    parameter bit OVF_WRAP = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  ras_op_e                    op,
    input  logic [$clog2(DEPTH)-1:0]   snap_ptr,
    input  logic [$clog2(DEPTH+1)-1:0] snap_cnt,
    output logic [$clog2(DEPTH)-1:0]   ptr_q,
    output logic [$clog2(DEPTH+1)-1:0] cnt_q,
    output logic [$clog2(DEPTH)-1:0]   ptr_d,
    output logic [$clog2(DEPTH+1)-1:0] cnt_d,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_idx,
    output logic                       err,
    output logic                       full,
    output logic                       valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] MAXC = CW'(DEPTH);

    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    // Explicit wrap so non-power-of-two depths stay in range.
    assign ptr_inc = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? LAST : ptr_q - PW'(1);

    assign full  = (cnt_q == MAXC);
    assign valid = (cnt_q != '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        err    = 1'b0;
        unique case (op)
            RAS_RESTORE: begin
                ptr_d  = snap_ptr;
                cnt_d  = snap_cnt;
                wr_en  = 1'b1;
                wr_idx = snap_ptr;
            end
            RAS_REPL: begin
                wr_en = 1'b1;
                if (!valid) begin
                    // Nothing to replace: behave as a push.
                    ptr_d  = ptr_inc;
                    wr_idx = ptr_inc;
                    cnt_d  = CW'(1);
                    err    = 1'b1;
                end
            end
            RAS_POP: begin
                if (valid) begin
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    err = 1'b1;
                end
            end
            RAS_PUSH: begin
                if (!full) begin
                    ptr_d  = ptr_inc;
                    wr_en  = 1'b1;
                    wr_idx = ptr_inc;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    err = 1'b1;
                    if (OVF_WRAP) begin
                        ptr_d  = ptr_inc;
                        wr_en  = 1'b1;
                        wr_idx = ptr_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ras_spec.sv
// Parametrised return-address stack with overflow mode, replace-top and
// one-deep checkpoint. Ports: clk, rst (async high), bus (slave modport).
module ras_spec
    import cpu_pkg::*;
#(
    parameter int WIDTH    = RAS_WIDTH,
    parameter int DEPTH    = RAS_DEPTH,
    parameter bit OVF_WRAP = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    ras_spec_if.slave      bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    ras_op_e          op;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, wr_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    logic [PW-1:0]    snap_ptr_q, snap_ptr_d;
    logic [CW-1:0]    snap_cnt_q, snap_cnt_d;
    logic [WIDTH-1:0] snap_top_q, snap_top_d;

    always_comb begin
        op = RAS_NONE;
        if (bus.ckpt_restore)
            op = RAS_RESTORE;
        else if (bus.push && bus.pop)
            op = RAS_REPL;
        else if (bus.pop)
            op = RAS_POP;
        else if (bus.push)
            op = RAS_PUSH;
    end

    ras_ptr_ctl #(
        .DEPTH    (DEPTH),
        .OVF_WRAP (OVF_WRAP)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .snap_ptr (snap_ptr_q),
        .snap_cnt (snap_cnt_q),
        .ptr_q    (ptr_q),
        .cnt_q    (cnt_q),
        .ptr_d    (ptr_d),
        .cnt_d    (cnt_d),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .err      (bus.err),
        .full     (bus.full),
        .valid    (bus.valid)
    );

    // Restore repairs the saved top, which later pushes may have clobbered.
    assign wr_data = (op == RAS_RESTORE) ? snap_top_q : bus.new_data;

    // Snapshot reflects the state after this cycle's update.
    always_comb begin
        snap_ptr_d = snap_ptr_q;
        snap_cnt_d = snap_cnt_q;
        snap_top_d = snap_top_q;
        if (bus.ckpt_save && op != RAS_RESTORE) begin
            snap_ptr_d = ptr_d;
            snap_cnt_d = cnt_d;
            if (cnt_d == '0)
                snap_top_d = '0;
            else if (wr_en && wr_idx == ptr_d)
                snap_top_d = bus.new_data;
            else
                snap_top_d = mem_q[ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_ptr_q <= '0;
            snap_cnt_q <= '0;
            snap_top_q <= '0;
        end else begin
            snap_ptr_q <= snap_ptr_d;
            snap_cnt_q <= snap_cnt_d;
            snap_top_q <= snap_top_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_idx] <= wr_data;
    end

    assign bus.count        = cnt_q;
    assign bus.top_of_stack = (cnt_q != '0) ? mem_q[ptr_q] : '0;

endmodule

// File: tb/tb_ras_spec.sv
// Testbench for ras_spec: directed vector table, drop-mode overflow,
// and randomized ops on three configurations against a queue model.
module tb_ras_spec;

    typedef logic [15:0] q_t [$];

    typedef struct {
        string       nm;
        logic        pu, po, sv, rs;
        logic [15:0] d;
        logic        e_err;
        logic [15:0] e_top;
        int          e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, save, rest;
    logic [15:0] data;

    int n_pass = 0;
    int n_total = 0;

    vec_t tv [$];
    q_t   q8w, q8d, q5;

    ras_spec_if #(.WIDTH(16), .DEPTH(8)) if8w ();
    ras_spec_if #(.WIDTH(16), .DEPTH(8)) if8d ();
    ras_spec_if #(.WIDTH(16), .DEPTH(5)) if5 ();

    assign if8w.push = push;  assign if8w.pop = pop;
    assign if8w.ckpt_save = save;  assign if8w.ckpt_restore = rest;
    assign if8w.new_data = data;
    assign if8d.push = push;  assign if8d.pop = pop;
    assign if8d.ckpt_save = save;  assign if8d.ckpt_restore = rest;
    assign if8d.new_data = data;
    assign if5.push = push;  assign if5.pop = pop;
    assign if5.ckpt_save = save;  assign if5.ckpt_restore = rest;
    assign if5.new_data = data;

    ras_spec #(.WIDTH(16), .DEPTH(8), .OVF_WRAP(1'b1)) u8w (
        .clk(clk), .rst(rst), .bus(if8w));
    ras_spec #(.WIDTH(16), .DEPTH(8), .OVF_WRAP(1'b0)) u8d (
        .clk(clk), .rst(rst), .bus(if8d));
    ras_spec #(.WIDTH(16), .DEPTH(5), .OVF_WRAP(1'b1)) u5 (
        .clk(clk), .rst(rst), .bus(if5));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input string nm, input bit pu, po, sv, rs,
                       input int d, input bit ee, input int et,
                       input int ec);
        vec_t v;
        v.nm = nm; v.pu = pu; v.po = po; v.sv = sv; v.rs = rs;
        v.d = 16'(d); v.e_err = ee; v.e_top = 16'(et); v.e_cnt = ec;
        tv.push_back(v);
    endtask

    task automatic drive(input bit pu, po, sv, rs, input logic [15:0] d);
        @(negedge clk);
        push = pu; pop = po; save = sv; rest = rs; data = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 0; pop = 0; save = 0; rest = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: queue holds live entries, oldest at front.
    function automatic void mstep(inout q_t q, input int dep,
                                  input bit wrap, input bit pu, po,
                                  input logic [15:0] d, output bit e);
        e = 1'b0;
        if (pu && po) begin
            if (q.size() > 0) begin
                void'(q.pop_back());
            end else begin
                e = 1'b1;
            end
            q.push_back(d);
        end else if (po) begin
            if (q.size() > 0) void'(q.pop_back());
            else e = 1'b1;
        end else if (pu) begin
            if (q.size() < dep) begin
                q.push_back(d);
            end else begin
                e = 1'b1;
                if (wrap) begin
                    void'(q.pop_front());
                    q.push_back(d);
                end
            end
        end
    endfunction

    function automatic logic [15:0] mtop(input q_t q);
        return (q.size() > 0) ? q[q.size()-1] : 16'h0;
    endfunction

    initial begin
        bit e8w, e8d, e5;
        int r;
        logic [15:0] rd;
        bit pu, po;

        rst = 1'b1;
        push = 0; pop = 0; save = 0; rest = 0; data = '0;
        #2;
        chk("rst_count", 32'(if8w.count), 0);
        chk("rst_valid", 32'(if8w.valid), 0);
        chk("rst_full", 32'(if8w.full), 0);
        chk("rst_top", 32'(if8w.top_of_stack), 0);
        chk("rst_err", 32'(if8w.err), 0);
        @(negedge clk);
        rst = 1'b0;

        add("t1_pop_empty", 0, 1, 0, 0, 0, 1, 0, 0);
        add("t2_push1", 1, 0, 0, 0, 'h1000, 0, 'h1000, 1);
        add("t2_push2", 1, 0, 0, 0, 'h2000, 0, 'h2000, 2);
        add("t2_push3", 1, 0, 0, 0, 'h3000, 0, 'h3000, 3);
        add("t2_pop1", 0, 1, 0, 0, 0, 0, 'h2000, 2);
        add("t2_pop2", 0, 1, 0, 0, 0, 0, 'h1000, 1);
        add("t2_pop3", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            add($sformatf("t3_push%0d", k), 1, 0, 0, 0, k,
                k == 9, k, (k > 8) ? 8 : k);
        for (int k = 1; k <= 8; k++)
            add($sformatf("t3_pop%0d", k), 0, 1, 0, 0, 0, 0,
                (k == 8) ? 0 : 9 - k, 8 - k);
        add("t4_push", 1, 0, 0, 0, 'hA, 0, 'hA, 1);
        add("t4_repl", 1, 1, 0, 0, 'hB, 0, 'hB, 1);
        add("t4_pop", 0, 1, 0, 0, 0, 0, 0, 0);
        add("t4_repl_empty", 1, 1, 0, 0, 'hC, 1, 'hC, 1);
        add("t4_pop2", 0, 1, 0, 0, 0, 0, 0, 0);
        add("t5_push10", 1, 0, 0, 0, 'h10, 0, 'h10, 1);
        add("t5_push20", 1, 0, 0, 0, 'h20, 0, 'h20, 2);
        add("t5_save", 0, 0, 1, 0, 0, 0, 'h20, 2);
        add("t5_pop", 0, 1, 0, 0, 0, 0, 'h10, 1);
        add("t5_push99", 1, 0, 0, 0, 'h99, 0, 'h99, 2);
        add("t5_restore", 1, 1, 1, 1, 'h77, 0, 'h20, 2);
        add("t5_pop_after", 0, 1, 0, 0, 0, 0, 'h10, 1);
        add("t5_pop_last", 0, 1, 0, 0, 0, 0, 0, 0);

        foreach (tv[i]) begin
            drive(tv[i].pu, tv[i].po, tv[i].sv, tv[i].rs, tv[i].d);
            chk({tv[i].nm, "_err"}, 32'(if8w.err), 32'(tv[i].e_err));
            @(posedge clk);
            #1;
            chk({tv[i].nm, "_top"}, 32'(if8w.top_of_stack),
                32'(tv[i].e_top));
            chk({tv[i].nm, "_cnt"}, 32'(if8w.count), 32'(tv[i].e_cnt));
            chk({tv[i].nm, "_valid"}, 32'(if8w.valid),
                32'(tv[i].e_cnt != 0));
            chk({tv[i].nm, "_full"}, 32'(if8w.full),
                32'(tv[i].e_cnt == 8));
        end

        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(1, 0, 0, 0, 16'(k));
            chk($sformatf("drop_push%0d_err", k), 32'(if8d.err),
                32'(k == 9));
            @(posedge clk);
            #1;
            chk($sformatf("drop_push%0d_cnt", k), 32'(if8d.count),
                (k > 8) ? 8 : k);
            chk($sformatf("drop_push%0d_top", k),
                32'(if8d.top_of_stack), (k > 8) ? 8 : k);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1, 0, 0, 16'h0);
            @(posedge clk);
            #1;
            chk($sformatf("drop_pop%0d_top", k),
                32'(if8d.top_of_stack), 8 - k);
            chk($sformatf("drop_pop%0d_cnt", k), 32'(if8d.count), 8 - k);
        end

        do_reset();
        q8w.delete(); q8d.delete(); q5.delete();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 3);
            pu = (r != 1);
            po = (r == 1) || (r == 2);
            rd = 16'($urandom);
            drive(pu, po, 0, 0, rd);
            mstep(q8w, 8, 1'b1, pu, po, rd, e8w);
            mstep(q8d, 8, 1'b0, pu, po, rd, e8d);
            mstep(q5, 5, 1'b1, pu, po, rd, e5);
            chk($sformatf("rnd%0d_8w_err", i), 32'(if8w.err), 32'(e8w));
            chk($sformatf("rnd%0d_8d_err", i), 32'(if8d.err), 32'(e8d));
            chk($sformatf("rnd%0d_5_err", i), 32'(if5.err), 32'(e5));
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_8w_top", i), 32'(if8w.top_of_stack),
                32'(mtop(q8w)));
            chk($sformatf("rnd%0d_8w_cnt", i), 32'(if8w.count),
                q8w.size());
            chk($sformatf("rnd%0d_8d_top", i), 32'(if8d.top_of_stack),
                32'(mtop(q8d)));
            chk($sformatf("rnd%0d_8d_cnt", i), 32'(if8d.count),
                q8d.size());
            chk($sformatf("rnd%0d_5_top", i), 32'(if5.top_of_stack),
                32'(mtop(q5)));
            chk($sformatf("rnd%0d_5_cnt", i), 32'(if5.count), q5.size());
        end

        drive(1, 0, 0, 0, 16'h55);
        @(posedge clk);
        #1;
        chk("pre_rst_5_valid", 32'(if5.valid), 1);
        @(negedge clk);
        push = 0; pop = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_5_cnt", 32'(if5.count), 0);
        chk("async_rst_5_valid", 32'(if5.valid), 0);
        chk("async_rst_5_top", 32'(if5.top_of_stack), 0);
        chk("async_rst_8w_cnt", 32'(if8w.count), 0);
        chk("async_rst_8d_valid", 32'(if8d.valid), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_5_cnt", 32'(if5.count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
